// File: rtl/video_timing_gen.sv
// Raster timing generator with registered blank/sync, blank-gated RGB and line/frame strobes; define VTG_SYNC_OFFSET_EN to enable hoffs/voffs.
// Latency: blank/sync/rgb_out describe the pixel at (hcnt, vcnt) one ce_pix later; hpos/vpos are combinational from the counters.
// Backpressure: none; state advances on every ce_pix and holds otherwise.
module video_timing_gen #(
    parameter int CNT_W        = 9,
    parameter int H_TOTAL      = 384,
    parameter int H_ACT_START  = 24,
    parameter int H_ACTIVE     = 240,
    parameter int H_SYNC_START = 288,
    parameter int H_SYNC_WIDTH = 32,
    parameter int V_TOTAL      = 263,
    parameter int V_ACTIVE     = 224,
    parameter int V_SYNC_START = 226,
    parameter int V_SYNC_WIDTH = 6,
    parameter int HOFFS_W      = 5,
    parameter int VOFFS_W      = 3,
    parameter int RGB_W        = 12
) (
    input  logic               clk_sys,
    input  logic               reset,
    input  logic               ce_pix,
    input  logic [HOFFS_W-1:0] hoffs,
    input  logic [VOFFS_W-1:0] voffs,
    input  logic [RGB_W-1:0]   rgb_in,
    output logic [CNT_W-1:0]   hpos,
    output logic [CNT_W-1:0]   vpos,
    output logic               hblank,
    output logic               vblank,
    output logic               hsync,
    output logic               vsync,
    output logic [RGB_W-1:0]   rgb_out,
    output logic               line_start,
    output logic               frame_start
);

    localparam int XW = CNT_W + 1;

    localparam logic [XW-1:0]    H_TOT  = XW'(H_TOTAL);
    localparam logic [XW-1:0]    V_TOT  = XW'(V_TOTAL);
    localparam logic [XW-1:0]    H_AS   = XW'(H_ACT_START);
    localparam logic [XW-1:0]    H_AE   = XW'(H_ACT_START + H_ACTIVE);
    localparam logic [XW-1:0]    V_ACT  = XW'(V_ACTIVE);
    localparam logic [XW-1:0]    H_SS   = XW'(H_SYNC_START);
    localparam logic [XW-1:0]    V_SS   = XW'(V_SYNC_START);
    localparam logic [XW-1:0]    H_SW   = XW'(H_SYNC_WIDTH);
    localparam logic [XW-1:0]    V_SW   = XW'(V_SYNC_WIDTH);
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ORG  = CNT_W'(H_ACT_START);

    generate
        if ((H_ACT_START + H_ACTIVE > H_TOTAL) || (V_ACTIVE > V_TOTAL) ||
            (H_SYNC_WIDTH == 0) || (H_SYNC_WIDTH >= H_TOTAL) ||
            (V_SYNC_WIDTH == 0) || (V_SYNC_WIDTH >= V_TOTAL) ||
            (H_TOTAL > (1 << CNT_W)) || (V_TOTAL > (1 << CNT_W))) begin : g_param_err
            $error("video_timing_gen: inconsistent raster geometry parameters");
        end
    endgenerate

    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] vcnt;
    logic             h_wrap;
    logic             v_wrap;
    logic [XW-1:0]    hs_start;
    logic [XW-1:0]    vs_start;

    assign h_wrap = (hcnt == H_LAST);
    assign v_wrap = (vcnt == V_LAST);

`ifdef VTG_SYNC_OFFSET_EN
    logic [HOFFS_W-1:0] hoffs_l;
    logic [VOFFS_W-1:0] voffs_l;
    logic [XW-1:0]      hs_sum;
    logic [XW-1:0]      vs_sum;

    // Offsets only move on the frame wrap so a frame never carries two sync positions.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            hoffs_l <= '0;
            voffs_l <= '0;
        end else if (ce_pix && h_wrap && v_wrap) begin
            hoffs_l <= hoffs;
            voffs_l <= voffs;
        end
    end

    assign hs_sum   = H_SS + XW'({hoffs_l, 1'b0});
    assign vs_sum   = V_SS + XW'(voffs_l);
    assign hs_start = (hs_sum >= H_TOT) ? hs_sum - H_TOT : hs_sum;
    assign vs_start = (vs_sum >= V_TOT) ? vs_sum - V_TOT : vs_sum;
`else
    logic unused_offs;

    assign unused_offs = ^{hoffs, voffs};
    assign hs_start    = H_SS;
    assign vs_start    = V_SS;
`endif

    logic [XW-1:0] h_x;
    logic [XW-1:0] v_x;
    logic [XW-1:0] hs_dist;
    logic [XW-1:0] vs_dist;
    logic          hblank_dec;
    logic          vblank_dec;
    logic          hsync_dec;
    logic          vsync_dec;

    // Modular distance from the sync start lets a window straddle the counter wrap.
    always_comb begin
        h_x        = {1'b0, hcnt};
        v_x        = {1'b0, vcnt};
        hs_dist    = (h_x >= hs_start) ? h_x - hs_start : h_x + H_TOT - hs_start;
        vs_dist    = (v_x >= vs_start) ? v_x - vs_start : v_x + V_TOT - vs_start;
        hsync_dec  = (hs_dist < H_SW);
        vsync_dec  = (vs_dist < V_SW);
        hblank_dec = !((h_x >= H_AS) && (h_x < H_AE));
        vblank_dec = !(v_x < V_ACT);
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            hcnt        <= '0;
            vcnt        <= '0;
            hblank      <= 1'b1;
            vblank      <= 1'b1;
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            rgb_out     <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (ce_pix) begin
                hblank      <= hblank_dec;
                vblank      <= vblank_dec;
                hsync       <= hsync_dec;
                vsync       <= vsync_dec;
                rgb_out     <= (hblank_dec || vblank_dec) ? '0 : rgb_in;
                line_start  <= h_wrap;
                frame_start <= h_wrap && v_wrap;
                if (h_wrap) begin
                    hcnt <= '0;
                    vcnt <= v_wrap ? '0 : vcnt + 1'b1;
                end else begin
                    hcnt <= hcnt + 1'b1;
                end
            end
        end
    end

    assign hpos = hcnt - H_ORG;
    assign vpos = vcnt;

endmodule
